// File: rtl/sample_stream_if.sv
// ---------------------------------------------------------------------------
// sample_stream_if
//   Stream bundle between the SHAKE output buffer, the CDF error sampler and
//   the matrix-multiply operand memory.
//
//   i_r          LANES x 16-bit random words, lane k = bits [16k+15:16k]
//   i_r_valid    random beat valid
//   o_r_ready    sampler accepts the random beat this cycle
//   o_e          LANES x E_WIDTH signed samples (two's complement)
//   o_e_16       LANES x Q_WIDTH samples mod q
//   o_lane_mask  1 = lane carries a real sample
//   o_valid      sample beat valid
//   i_ready      downstream accepts the sample beat
//
//   slave  : sampler view
//   master : environment view (random source + sample sink)
// ---------------------------------------------------------------------------
interface sample_stream_if #(
  parameter int LANES   = 4,
  parameter int R_WIDTH = 16,
  parameter int E_WIDTH = 5,
  parameter int Q_WIDTH = 16
);
  logic [LANES*R_WIDTH-1:0] i_r;
  logic                     i_r_valid;
  logic                     o_r_ready;
  logic [LANES*E_WIDTH-1:0] o_e;
  logic [LANES*Q_WIDTH-1:0] o_e_16;
  logic [LANES-1:0]         o_lane_mask;
  logic                     o_valid;
  logic                     i_ready;

  modport slave (
    input  i_r, i_r_valid, i_ready,
    output o_r_ready, o_e, o_e_16, o_lane_mask, o_valid
  );

  modport master (
    output i_r, i_r_valid, i_ready,
    input  o_r_ready, o_e, o_e_16, o_lane_mask, o_valid
  );
endinterface

// File: rtl/sample_stream.sv
// ---------------------------------------------------------------------------
// sample_stream
//   Multi-lane, two-stage pipelined CDF error sampler for the FrodoKEM
//   error-matrix path. Each 16-bit random word becomes one error sample:
//   bit 0 is the sign, bits 15:1 index the CDF table of the latched level.
//
//   i_clk          clock
//   i_rst          synchronous active-high reset
//   i_start        start request, honoured only in IDLE
//   i_sec_level    1, 3 or 5 (anything else behaves as 1), latched on start
//   i_num_samples  samples in this run, latched on start
//   strm           random input / sample output stream (slave side)
//   o_busy         run in progress (state != IDLE)
//   o_done         one-cycle pulse at the end of a run
// ---------------------------------------------------------------------------
module sample_stream #(
  parameter int LANES   = 4,
  parameter int R_WIDTH = 16,
  parameter int E_WIDTH = 5,
  parameter int Q_WIDTH = 16,
  parameter int N_WIDTH = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [2:0]         i_sec_level,
  input  logic [N_WIDTH-1:0] i_num_samples,
  sample_stream_if.slave     strm,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam logic [1:0] SEC_L1 = 2'd0;
  localparam logic [1:0] SEC_L3 = 2'd1;
  localparam logic [1:0] SEC_L5 = 2'd2;

  // Level 1 is reduced mod 2^15; this clears the top bit of a 16-bit negation.
  localparam logic [Q_WIDTH-1:0] L1_MOD_MASK = Q_WIDTH'(32'h7FFF);

  // Shorter tables are padded with 7FFF, which no 15-bit index exceeds, so
  // every level can share one 13-entry compare loop.
  localparam logic [14:0] THR_L1 [13] = '{
    15'h1223, 15'h3433, 15'h5063, 15'h64F3, 15'h722B, 15'h79A9, 15'h7D67,
    15'h7F0D, 15'h7FB1, 15'h7FE9, 15'h7FFA, 15'h7FFE, 15'h7FFF};
  localparam logic [14:0] THR_L3 [13] = '{
    15'h1606, 15'h3E2B, 15'h5C89, 15'h6F9B, 15'h798C, 15'h7DD9, 15'h7F65,
    15'h7FDB, 15'h7FF8, 15'h7FFE, 15'h7FFF, 15'h7FFF, 15'h7FFF};
  localparam logic [14:0] THR_L5 [13] = '{
    15'h23B6, 15'h5BA6, 15'h7682, 15'h7E69, 15'h7FD5, 15'h7FFD, 15'h7FFF,
    15'h7FFF, 15'h7FFF, 15'h7FFF, 15'h7FFF, 15'h7FFF, 15'h7FFF};

  // Magnitude = number of thresholds strictly below the index.
  function automatic logic [3:0] sample_mag(input logic [14:0] rs, input logic [1:0] sec);
    logic [3:0]  cnt;
    logic [14:0] thr;
    cnt = '0;
    for (int i = 0; i < 13; i++) begin
      if (sec == SEC_L5)      thr = THR_L5[i];
      else if (sec == SEC_L3) thr = THR_L3[i];
      else                    thr = THR_L1[i];
      if (rs > thr) cnt = cnt + 4'd1;
    end
    return cnt;
  endfunction

  state_t state_reg, state_next;

  // Run configuration (latched on an accepted start)
  logic [1:0]         sec_reg;
  logic [N_WIDTH-1:0] beats_total_reg;
  logic [N_WIDTH-1:0] rem_reg;
  logic [N_WIDTH-1:0] beats_in_reg;

  // Stage 1: raw random beat
  logic                     s1_valid_reg;
  logic [LANES*R_WIDTH-1:0] s1_r_reg;
  logic [LANES-1:0]         s1_mask_reg;
  logic [1:0]               s1_sec_reg;

  // Stage 2: converted samples
  logic                     s2_valid_reg;
  logic [LANES*E_WIDTH-1:0] e_reg, e_next;
  logic [LANES*Q_WIDTH-1:0] e16_reg, e16_next;
  logic [LANES-1:0]         mask_reg;

  logic               start_accept;
  logic               in_fire;
  logic               last_beat;
  logic               s1_adv;
  logic               s2_adv;
  logic [1:0]         sec_dec;
  logic [N_WIDTH-1:0] rem_calc;
  logic [N_WIDTH-1:0] beats_calc;
  logic [LANES-1:0]   in_mask;

  assign start_accept = (state_reg == IDLE) && i_start;

  always_comb begin
    case (i_sec_level)
      3'd3:    sec_dec = SEC_L3;
      3'd5:    sec_dec = SEC_L5;
      default: sec_dec = SEC_L1;
    endcase
  end

  // ceil(num/LANES) without widening: quotient plus one if a remainder exists.
  assign rem_calc   = i_num_samples % N_WIDTH'(LANES);
  assign beats_calc = (i_num_samples / N_WIDTH'(LANES)) + N_WIDTH'(rem_calc != '0);

  assign s2_adv    = !s2_valid_reg || strm.i_ready;
  assign s1_adv    = !s1_valid_reg || s2_adv;
  assign last_beat = (beats_in_reg + N_WIDTH'(1)) == beats_total_reg;

  assign strm.o_r_ready = (state_reg == RUN) && (beats_in_reg < beats_total_reg) && s1_adv;
  assign in_fire        = strm.i_r_valid && strm.o_r_ready;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (i_start) state_next = (i_num_samples == '0) ? DONE : RUN;
      RUN:     if (in_fire && last_beat) state_next = FLUSH;
      FLUSH:   if (!s1_valid_reg && !s2_valid_reg) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    o_busy = (state_reg != IDLE);
    o_done = (state_reg == DONE);
  end

  // ---------------- Per-lane logic ----------------
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [14:0]        rs;
    logic               sgn;
    logic [3:0]         mag;
    logic [E_WIDTH-1:0] e_pos;
    logic [Q_WIDTH-1:0] q_pos;
    logic [Q_WIDTH-1:0] q_neg;

    // Only the tail beat of a run with a remainder has masked lanes.
    assign in_mask[gi] = !(last_beat && (rem_reg != '0) && (N_WIDTH'(gi) >= rem_reg));

    assign rs    = s1_r_reg[gi*R_WIDTH+1 +: 15];
    assign sgn   = s1_r_reg[gi*R_WIDTH];
    assign mag   = sample_mag(rs, s1_sec_reg);
    assign e_pos = E_WIDTH'(mag);
    assign q_pos = Q_WIDTH'(mag);
    // mag = 0 negates to 0, so a negative zero collapses to 0 in both forms.
    assign q_neg = (s1_sec_reg == SEC_L1) ? ((Q_WIDTH'(0) - q_pos) & L1_MOD_MASK)
                                          : (Q_WIDTH'(0) - q_pos);

    assign e_next[gi*E_WIDTH +: E_WIDTH] =
      !s1_mask_reg[gi] ? '0 : (sgn ? (E_WIDTH'(0) - e_pos) : e_pos);
    assign e16_next[gi*Q_WIDTH +: Q_WIDTH] =
      !s1_mask_reg[gi] ? '0 : (sgn ? q_neg : q_pos);
  end

  // ---------------- Datapath ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sec_reg         <= SEC_L1;
      beats_total_reg <= '0;
      rem_reg         <= '0;
      beats_in_reg    <= '0;
      s1_valid_reg    <= 1'b0;
      s1_r_reg        <= '0;
      s1_mask_reg     <= '0;
      s1_sec_reg      <= SEC_L1;
      s2_valid_reg    <= 1'b0;
      e_reg           <= '0;
      e16_reg         <= '0;
      mask_reg        <= '0;
    end else begin
      if (start_accept) begin
        sec_reg         <= sec_dec;
        beats_total_reg <= beats_calc;
        rem_reg         <= rem_calc;
        beats_in_reg    <= '0;
      end else if (in_fire) begin
        beats_in_reg <= beats_in_reg + N_WIDTH'(1);
      end

      if (s1_adv) begin
        s1_valid_reg <= in_fire;
        if (in_fire) begin
          s1_r_reg    <= strm.i_r;
          s1_mask_reg <= in_mask;
          s1_sec_reg  <= sec_reg;
        end
      end

      // Empty slots are loaded with zeros so idle outputs read as 0.
      if (s2_adv) begin
        s2_valid_reg <= s1_valid_reg;
        e_reg        <= s1_valid_reg ? e_next      : '0;
        e16_reg      <= s1_valid_reg ? e16_next    : '0;
        mask_reg     <= s1_valid_reg ? s1_mask_reg : '0;
      end
    end
  end

  assign strm.o_valid     = s2_valid_reg;
  assign strm.o_e         = e_reg;
  assign strm.o_e_16      = e16_reg;
  assign strm.o_lane_mask = mask_reg;

endmodule
